me_dm_access: RTL
=================

Name: me_dm_access

Overview:
- Memory-stage consumer of the EX/ME pipeline register outputs for the MIPS pipeline.
- Converts the stage's data-memory request into a handshaked word bus transaction:
  - computes byte enables and lane-replicated store data;
  - aligns and extends load data;
  - detects address-alignment exceptions;
  - stalls the pipeline until the bus acknowledges.
- Sits between the EX/ME register and the system bridge / data memory; feeds the ME/WB register.

Parameters:
- TIMEOUT_CYCLES, 255: maximum REQ cycles before abort (used only with BUS_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- addr  in  32  byte address (ALU output from EX/ME)
- wdata  in  32  store data, right-aligned
- we  in  1  store request
- rd  in  1  load request
- wid  in  3  access width: 3'd0 word, 3'd1 half, 3'd2 byte; other codes treated as word
- sign  in  1  1 = sign-extend loads, 0 = zero-extend
- exc_in  in  5  exception code carried from EX/ME; 0 = none
- flush  in  1  exception taken this cycle; suppresses a new access
- stall  out  1  hold F/D/E/ME stages
- rdata  out  32  aligned, extended load result
- exc_out  out  5  exception code forwarded to ME/WB
- bus_req  out  1  transaction request
- bus_we  out  1  transaction is a write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bridge completion strobe
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Clocking and reset:
  - One clock domain; all state changes happen on the rising edge of clk.
  - reset is synchronous and active-high.
  - Reset values: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, rdata=0, captured lane/width/sign=0, timeout counter=0.
  - Outputs with no registered state during reset: stall=0, exc_out=exc_in.
- Misalignment (combinational):
  - Half-word access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - exc_out priority:
    1. exc_in if nonzero;
    2. else 4 (AdEL) for a misaligned load, or 5 (AdES) for a misaligned store;
    3. else the latched timeout code (7, DBE) while in DONE;
    4. else 0.
- Access start: start = (we|rd) & exc_in==0 & !misaligned & !flush & state==IDLE. If we and rd are both 1, the access is a store.
- FSM:
  - IDLE:
    - If start: stall=1 combinationally.
    - On that edge, register bus_req=1, bus_we, bus_addr, bus_be and bus_wdata; latch addr[1:0], wid and sign; go to REQ.
  - REQ:
    - stall=1; bus outputs held stable.
    - On bus_ack=1: capture bus_rdata, drop bus_req (registered), go to DONE. An ack in the first REQ cycle is legal.
    - flush is ignored: an issued access always completes.
  - DONE:
    - stall=0; rdata is valid; the pipeline advances at the end of this cycle.
    - Always return to IDLE (no restart for the same instruction).
- Minimum access latency: 3 cycles (IDLE start, REQ, DONE). Back-to-back accesses restart in the IDLE cycle that follows DONE.
- Byte enables and store data:
  - word: be=4'b1111, data = wdata.
  - half: be=4'b0011 << addr[1:0], data = {2{wdata[15:0]}}.
  - byte: be=4'b0001 << addr[1:0], data = {4{wdata[7:0]}}.
- Load result: select the lane by the latched addr[1:0], then sign- or zero-extend per the latched sign. Word loads pass through unchanged.
- Idle outputs: rdata holds its last value outside DONE. bus_req never asserts without a preceding start.
- Reset during REQ: returns to IDLE; bus_req=0 on the following edge; any later ack is ignored.

Optional Feature:
- Macro: BUS_TIMEOUT_EN.
- Defined:
  - A counter counts REQ cycles.
  - If it reaches TIMEOUT_CYCLES without ack: drop bus_req, go to DONE, rdata=0, exc_out=7 in that DONE cycle.
  - The counter clears on leaving REQ.
- Undefined: no counter; REQ waits for ack indefinitely.

Test Plan:
- Word load: addr=0x100, rd=1, ack after 2 cycles with rdata=0xDEADBEEF -> stall high for 3 cycles, bus_be=1111, rdata=0xDEADBEEF in DONE.
- Signed byte load: addr=0x103, wid=2, sign=1, bus_rdata=0x80AABBCC -> rdata=0xFFFFFF80; with sign=0 -> rdata=0x00000080.
- Half store: addr=0x202, wid=1, wdata=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200, bus_we=1.
- Misaligned word store: addr=0x105, we=1 -> exc_out=5, bus_req stays 0, stall=0. exc_in=10 with rd=1 -> exc_out=10, no access.
- Reset asserted in REQ -> IDLE next edge, bus_req=0; a later ack produces no DONE. flush=1 in IDLE with a valid load -> no bus_req.
- With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 REQ cycles, exc_out=7, stall releases.

Source files
------------

// File: rtl/me_dm_access_if.sv
// rtl/me_dm_access_if.sv - word bus between the ME-stage access unit and the bridge/data memory
interface me_dm_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/me_dm_access.sv
// rtl/me_dm_access.sv - ME-stage data-memory access: byte lanes, load align/extend, bus handshake, stall
// Optional feature macro: BUS_TIMEOUT_EN (abort REQ after TIMEOUT_CYCLES without ack, exc_out=7)
module me_dm_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        rd,
  input  logic [2:0]  wid,
  input  logic        sign,
  input  logic [4:0]  exc_in,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [4:0]  exc_out,
  me_dm_access_if.master bus
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [2:0]  wid_q;
  logic        sign_q;
  logic        timed_out;

  logic        is_half;
  logic        is_byte;
  logic        access;
  logic        misaligned;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_val;

  // A zero limit would time out before the first REQ cycle could be acknowledged
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] tmo_cnt;
  logic          timeout_q;

  assign timed_out = timeout_q;
`else
  assign timed_out = 1'b0;
`endif

  // Access decode: width class, alignment check and the start condition
  always_comb begin
    is_half = (wid == 3'd1);
    is_byte = (wid == 3'd2);
    access  = we | rd;
    if (is_byte) begin
      misaligned = 1'b0;
    end else if (is_half) begin
      misaligned = addr[0];
    end else begin
      misaligned = |addr[1:0];
    end
    start = access && (exc_in == EXC_NONE) && !misaligned && !flush && (state == IDLE);
  end

  // Byte enables and lane-replicated store data for the access about to issue
  always_comb begin
    if (is_byte) begin
      be_next    = 4'b0001 << addr[1:0];
      wdata_next = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_next    = 4'b0011 << addr[1:0];
      wdata_next = {2{wdata[15:0]}};
    end else begin
      be_next    = 4'b1111;
      wdata_next = wdata;
    end
  end

  // Load alignment: pick the lane captured at issue, then extend per the captured sign mode
  always_comb begin
    case (lane_q)
      2'd0:    load_byte = bus.bus_rdata[7:0];
      2'd1:    load_byte = bus.bus_rdata[15:8];
      2'd2:    load_byte = bus.bus_rdata[23:16];
      default: load_byte = bus.bus_rdata[31:24];
    endcase
    load_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
    if (wid_q == 3'd2) begin
      load_val = {{24{sign_q & load_byte[7]}}, load_byte};
    end else if (wid_q == 3'd1) begin
      load_val = {{16{sign_q & load_half[15]}}, load_half};
    end else begin
      load_val = bus.bus_rdata;
    end
  end

  // Pipeline-facing outputs: stall while an access is starting or outstanding; exception priority
  always_comb begin
    stall   = 1'b0;
    exc_out = exc_in;
    if (!reset) begin
      stall = start || (state == REQ);
      if (exc_in != EXC_NONE) begin
        exc_out = exc_in;
      end else if (access && misaligned) begin
        exc_out = we ? EXC_ADES : EXC_ADEL;
      end else if ((state == DONE) && timed_out) begin
        exc_out = EXC_DBE;
      end else begin
        exc_out = EXC_NONE;
      end
    end
  end

  // Access FSM: issue on start, hold the bus until ack (or timeout), present the result for one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= 32'd0;
      bus.bus_be    <= 4'd0;
      bus.bus_wdata <= 32'd0;
      rdata         <= 32'd0;
      lane_q        <= 2'd0;
      wid_q         <= 3'd0;
      sign_q        <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tmo_cnt       <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            bus.bus_req   <= 1'b1;
            bus.bus_we    <= we;
            bus.bus_addr  <= {addr[31:2], 2'b00};
            bus.bus_be    <= be_next;
            bus.bus_wdata <= wdata_next;
            lane_q        <= addr[1:0];
            wid_q         <= wid;
            sign_q        <= sign;
            state         <= REQ;
          end
        end
        REQ: begin
          if (bus.bus_ack) begin
            rdata       <= load_val;
            bus.bus_req <= 1'b0;
            state       <= DONE;
`ifdef BUS_TIMEOUT_EN
            tmo_cnt     <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            rdata       <= 32'd0;
            bus.bus_req <= 1'b0;
            timeout_q   <= 1'b1;
            tmo_cnt     <= '0;
            state       <= DONE;
          end else begin
            tmo_cnt     <= tmo_cnt + CW'(1);
`endif
          end
        end
        DONE: begin
          state     <= IDLE;
`ifdef BUS_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
